// File: rtl/shift_left_logical_seq_if.sv
// Request/response channel of the multi-cycle left-logical shifter.
//   valid_i/ready_o : request handshake, carrying rs1_i (value) and rs2_i (amount)
//   valid_o/ready_i : response handshake, carrying rd_o (result)
//   busy_o          : an operation is in flight (shifting or waiting to be taken)
// The slave modport is the shifter's view; the master modport is the requester/consumer's view.
interface shift_left_logical_seq_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] rs1_i;
  logic [WIDTH-1:0] rs2_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] rd_o;
  logic             busy_o;

  modport slave (
    input  valid_i, rs1_i, rs2_i, ready_i,
    output ready_o, valid_o, rd_o, busy_o
  );

  modport master (
    output valid_i, rs1_i, rs2_i, ready_i,
    input  ready_o, valid_o, rd_o, busy_o
  );
endinterface

// File: rtl/shift_left_logical_seq.sv
// Multi-cycle left-logical shifter (RV32 SLL/SLLI semantics). Shifts at most STEP bits per clock;
// a single operation is in flight at a time.
// Ports:
//   clk_i : clock, all state changes on the rising edge
//   rst_i : synchronous reset, active high; drops any in-flight operation
//   bus   : shift_left_logical_seq_if.slave
//           request  valid_i/ready_o with rs1_i (value) and rs2_i (amount, low SHAMT_W bits used)
//           response valid_o/ready_i with rd_o = rs1 << amt, zero-filled, 0 while valid_o is low
//           busy_o high while shifting or holding a result
module shift_left_logical_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  shift_left_logical_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One extra bit so STEP == WIDTH (e.g. 32 with a 5-bit counter) is representable.
  localparam logic [SHAMT_W:0] STEP_W = (SHAMT_W + 1)'(STEP);

  state_t             state_reg;
  logic [WIDTH-1:0]   data_reg;
  logic [SHAMT_W-1:0] cnt_reg;
  logic               ready_reg;
  logic               valid_reg;
  logic               busy_reg;
  logic [WIDTH-1:0]   rd_reg;

  logic [SHAMT_W-1:0] amt_in;
  logic [SHAMT_W-1:0] step_next;
  logic [SHAMT_W-1:0] cnt_next;
  logic [WIDTH-1:0]   data_next;

  assign amt_in = bus.rs2_i[SHAMT_W-1:0];

  // Upper amount bits are architecturally ignored.
  generate
    if (WIDTH > SHAMT_W) begin : g_unused_hi
      logic unused_rs2_hi;
      assign unused_rs2_hi = ^bus.rs2_i[WIDTH-1:SHAMT_W];
    end
  endgenerate

  // Step size is min(STEP, remaining). When STEP exceeds the counter range the low bits of
  // STEP_W are never selected, because any remaining count is then below STEP.
  always_comb begin
    step_next = STEP_W[SHAMT_W-1:0];
    if ({1'b0, cnt_reg} < STEP_W) begin
      step_next = cnt_reg;
    end
    data_next = data_reg << step_next;
    cnt_next  = cnt_reg - step_next;
  end

  // Handshake flags and result are registered alongside the state so they always reflect it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      cnt_reg   <= '0;
      ready_reg <= 1'b1;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      rd_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.valid_i && ready_reg) begin
            data_reg  <= bus.rs1_i;
            cnt_reg   <= amt_in;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b1;
            if (amt_in == '0) begin
              state_reg <= DONE;
              valid_reg <= 1'b1;
              rd_reg    <= bus.rs1_i;
            end else begin
              state_reg <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data_reg <= data_next;
          cnt_reg  <= cnt_next;
          if (cnt_next == '0) begin
            state_reg <= DONE;
            valid_reg <= 1'b1;
            rd_reg    <= data_next;
          end
        end
        DONE: begin
          // Returning to IDLE here means the next accept is one cycle later at the earliest.
          if (bus.ready_i) begin
            state_reg <= IDLE;
            ready_reg <= 1'b1;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            rd_reg    <= '0;
          end
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
          rd_reg    <= '0;
        end
      endcase
    end
  end

  assign bus.ready_o = ready_reg;
  assign bus.valid_o = valid_reg;
  assign bus.busy_o  = busy_reg;
  assign bus.rd_o    = rd_reg;

endmodule

// File: tb/tb_shift_left_logical_seq.sv
// Bench for shift_left_logical_seq: three instances (STEP = 1, 4, 32) on one clock and reset,
// a directed vector table, hand-written reset/back-pressure sequences and a random run.
module tb_shift_left_logical_seq;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  shift_left_logical_seq_if #(.WIDTH(32)) u1 ();
  shift_left_logical_seq_if #(.WIDTH(32)) u4 ();
  shift_left_logical_seq_if #(.WIDTH(32)) u32 ();

  shift_left_logical_seq #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (u1)
  );

  shift_left_logical_seq #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut4 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (u4)
  );

  shift_left_logical_seq #(.WIDTH(32), .SHAMT_W(5), .STEP(32)) dut32 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (u32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          k;     // 0: STEP=1, 1: STEP=4, 2: STEP=32
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] exp;
    int          lat;   // edges from request presented to valid_o high
  } vec_t;

  vec_t vecs[10];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_req(int k, logic v, logic [31:0] a, logic [31:0] b);
    case (k)
      0:       begin u1.valid_i = v;  u1.rs1_i = a;  u1.rs2_i = b;  end
      1:       begin u4.valid_i = v;  u4.rs1_i = a;  u4.rs2_i = b;  end
      default: begin u32.valid_i = v; u32.rs1_i = a; u32.rs2_i = b; end
    endcase
  endtask

  task automatic set_rdy(int k, logic r);
    case (k)
      0:       u1.ready_i = r;
      1:       u4.ready_i = r;
      default: u32.ready_i = r;
    endcase
  endtask

  task automatic get_out(int k, output logic rdy, output logic vld, output logic bsy,
                         output logic [31:0] rd);
    case (k)
      0:       begin rdy = u1.ready_o;  vld = u1.valid_o;  bsy = u1.busy_o;  rd = u1.rd_o;  end
      1:       begin rdy = u4.ready_o;  vld = u4.valid_o;  bsy = u4.busy_o;  rd = u4.rd_o;  end
      default: begin rdy = u32.ready_o; vld = u32.valid_o; bsy = u32.busy_o; rd = u32.rd_o; end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(int k, string nm);
    logic rdy, vld, bsy;
    logic [31:0] rd;
    get_out(k, rdy, vld, bsy, rd);
    chk({nm, " ready_o"}, 32'(rdy), 32'd1);
    chk({nm, " valid_o"}, 32'(vld), 32'd0);
    chk({nm, " busy_o"},  32'(bsy), 32'd0);
    chk({nm, " rd_o"},    rd, 32'd0);
  endtask

  // One complete transaction. hold=1 keeps valid_i high with different operands while busy,
  // and still high in the DONE handshake cycle, to show nothing extra is accepted.
  task automatic run_op(int k, logic [31:0] a, logic [31:0] b, logic [31:0] exp, int lat,
                        int gap, int rdly, bit hold, string nm);
    logic rdy, vld, bsy;
    logic [31:0] rd;
    int cyc;
    repeat (gap) tick();
    get_out(k, rdy, vld, bsy, rd);
    chk({nm, " ready_o before"}, 32'(rdy), 32'd1);
    set_req(k, 1'b1, a, b);
    tick();
    cyc = 1;
    set_req(k, hold, ~a, b ^ 32'h5);
    get_out(k, rdy, vld, bsy, rd);
    chk({nm, " ready_o after accept"}, 32'(rdy), 32'd0);
    chk({nm, " busy_o after accept"},  32'(bsy), 32'd1);
    while (!vld && cyc < 200) begin
      tick();
      cyc++;
      get_out(k, rdy, vld, bsy, rd);
    end
    chk({nm, " latency"}, 32'(cyc), 32'(lat));
    chk({nm, " rd_o"}, rd, exp);
    for (int i = 0; i < rdly; i++) begin
      tick();
      get_out(k, rdy, vld, bsy, rd);
      chk({nm, " valid_o held"}, 32'(vld), 32'd1);
      chk({nm, " rd_o held"}, rd, exp);
    end
    set_rdy(k, 1'b1);
    tick();
    set_rdy(k, 1'b0);
    check_idle(k, {nm, " post"});
    set_req(k, 1'b0, 32'h0, 32'h0);
    $display("op %s k=%0d rs1=%h rs2=%h rd=%h lat=%0d", nm, k, a, b, rd, cyc);
  endtask

  function automatic int exp_lat(int amt, int step);
    return (amt == 0) ? 1 : 1 + (amt + step - 1) / step;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rdy, vld, bsy;
    logic [31:0] rd;
    int bad;
    checks   = 0;
    failures = 0;

    vecs[0] = '{0, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 1};
    vecs[1] = '{0, 32'h00000001, 32'd31,       32'h80000000, 32};
    vecs[2] = '{0, 32'h0000000F, 32'hFFFFFFE4, 32'h000000F0, 5};
    vecs[3] = '{0, 32'h80000001, 32'd1,        32'h00000002, 2};
    vecs[4] = '{1, 32'h12345678, 32'd6,        32'h8D159E00, 3};
    vecs[5] = '{1, 32'h00000001, 32'd31,       32'h80000000, 9};
    vecs[6] = '{1, 32'hA5A5A5A5, 32'd4,        32'h5A5A5A50, 2};
    vecs[7] = '{1, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 1};
    vecs[8] = '{2, 32'h12345678, 32'd6,        32'h8D159E00, 2};
    vecs[9] = '{2, 32'hFFFFFFFF, 32'd31,       32'h80000000, 2};

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_req(k, 1'b0, 32'h0, 32'h0);
      set_rdy(k, 1'b0);
    end
    tick();
    tick();
    rst = 1'b0;
    check_idle(0, "reset s1");
    check_idle(1, "reset s4");
    check_idle(2, "reset s32");

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].k, vecs[i].rs1, vecs[i].rs2, vecs[i].exp, vecs[i].lat, 1, 0, 1'b0,
             $sformatf("vec%0d", i));
    end

    // Back-pressure: result held for 10 cycles, request held high throughout.
    run_op(0, 32'h0000F00D, 32'd8, 32'h00F00D00, 9, 0, 10, 1'b1, "backpressure");

    // Reset mid-SHIFT: no result ever appears.
    set_req(0, 1'b1, 32'h00000001, 32'd20);
    tick();
    set_req(0, 1'b0, 32'h0, 32'h0);
    repeat (4) tick();
    get_out(0, rdy, vld, bsy, rd);
    chk("midshift busy_o", 32'(bsy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle(0, "midshift reset");
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      get_out(0, rdy, vld, bsy, rd);
      if (vld || bsy) bad++;
    end
    chk("midshift no valid_o", 32'(bad), 32'd0);
    $display("op midshift_reset k=0 cycles_with_valid=%0d", bad);

    // Reset while holding a result in DONE.
    set_req(1, 1'b1, 32'h00000055, 32'd0);
    tick();
    set_req(1, 1'b0, 32'h0, 32'h0);
    get_out(1, rdy, vld, bsy, rd);
    chk("done valid_o before reset", 32'(vld), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle(1, "done reset");
    $display("op done_reset k=1");

    // Random run on the STEP=1 instance.
    for (int i = 0; i < 100; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      int amt;
      a   = $urandom;
      amt = int'($urandom % 32);
      b   = ($urandom & 32'hFFFFFFE0) | 32'(amt);
      run_op(0, a, b, a << amt, exp_lat(amt, 1), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), 1'($urandom % 2), $sformatf("rnd%0d", i));
    end

    // Random run on the STEP=4 instance exercising short final steps.
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a;
      int amt;
      a   = $urandom;
      amt = int'($urandom % 32);
      run_op(1, a, 32'(amt), a << amt, exp_lat(amt, 4), int'($urandom_range(0, 2)),
             int'($urandom_range(0, 2)), 1'b0, $sformatf("rnd4_%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
